mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: maximum cycles a granted transfer waits for mem_ready.
REQ-002 SHALL have parameter TIMER_W, default 8: width of the timeout counter, with TIMEOUT_CYCLES < 2**TIMER_W.
REQ-003 SHALL have port clk, input, 1: single clock, all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have ports m0_valid/m1_valid, input, 1 each: master request.
REQ-006 SHALL have ports m0_ready/m1_ready, output, 1 each: transfer complete, pulsed for one cycle.
REQ-007 SHALL have ports m0_addr/m1_addr, m0_wdata/m1_wdata, input, 32 each: master address and write data.
REQ-008 SHALL have ports m0_wstrb/m1_wstrb, input, 4 each: byte strobes; 0 means read.
REQ-009 SHALL have ports m0_rdata/m1_rdata, output, 32 each: read data.
REQ-010 SHALL have ports mem_valid, output, 1; mem_ready, input, 1: downstream handshake.
REQ-011 SHALL have ports mem_addr/mem_wdata, output, 32; mem_wstrb, output, 4; mem_rdata, input, 32: downstream bus.
REQ-012 SHALL have ports bus_err, output, 1 (sticky timeout flag) and bus_err_addr, output, 32 (address of the first timed-out transfer).
REQ-013 SHALL have port err_clr, input, 1: clears bus_err.

Function
REQ-014 SHALL implement states IDLE, GNT0 and GNT1 with a registered grant.
REQ-015 In IDLE, SHALL move to GNT0 when only m0_valid is set, to GNT1 when only m1_valid is set, and to the master not served last when both are set (round-robin); SHALL stay in IDLE when neither is set.
REQ-016 In GNTx, mem_valid, mem_addr, mem_wdata and mem_wstrb SHALL be combinational copies of master x's signals; in IDLE they SHALL all be 0.
REQ-017 In GNTx, when mem_ready=1, mx_ready SHALL be 1 in that same cycle, mx_rdata SHALL equal mem_rdata, the last-served flag SHALL be set to x, and the state SHALL return to IDLE.
REQ-018 Minimum latency SHALL be: request seen in IDLE at cycle N, grant at N+1, completion at N+1 if the slave is zero-wait; hence a back-to-back requester gets one transfer every 2 cycles.
REQ-019 The ready and rdata outputs of the non-granted master SHALL be 0 at all times.
REQ-020 A timer SHALL clear on entry to GNTx and increment each granted cycle without mem_ready.
REQ-021 When the timer equals TIMEOUT_CYCLES and mem_ready=0, the arbiter SHALL assert mx_ready with mx_rdata=0 for one cycle, set bus_err, load bus_err_addr only if bus_err was 0, and return to IDLE.
REQ-022 If mem_ready=1 and timeout coincide, SHALL treat it as normal completion with no error.
REQ-023 If the granted master drops valid before completion (protocol violation), SHALL return to IDLE without asserting ready.
REQ-024 err_clr SHALL clear bus_err next cycle; if err_clr and a new timeout coincide, the arbiter SHALL keep bus_err=1 and load the new address.

Reset
REQ-025 On rst the arbiter SHALL set state=IDLE, timer=0, bus_err=0, bus_err_addr=0 and last-served=1, so m0 wins the first tie.
REQ-026 rst asserted mid-transfer SHALL abort it: no ready pulse, and mem_valid=0 from the next cycle.
REQ-027 All outputs SHALL be 0 while rst=1 and in the first cycle after it is released.

Structure
REQ-028 State encoding and the default TIMEOUT_CYCLES SHALL live in a shared header/package (mem_arb_pkg) for reuse by the SoC top level and benches.
REQ-029 The timeout counter SHALL be one sub-module, bus_timer (inputs clr, en; output expired), instantiated once.
REQ-030 The datapath muxing SHALL stay in mem_arbiter; there SHALL be no buffering of data and no added pipeline stage.

Verification
REQ-031 Only m0_valid, addr 0x100, wstrb 0, slave ready 1 cycle after grant returning rdata 0xDEADBEEF -> m0_ready pulses once with m0_rdata=0xDEADBEEF, m1_ready stays 0.
REQ-032 m0 and m1 valid together continuously after reset, zero-wait slave -> grants alternate m0, m1, m0, m1, one completion every 2 cycles.
REQ-033 m1 write, addr 0x03000004, wdata 0x12345678, wstrb 0xF -> mem_* carry exactly those values only during GNT1; wstrb is 0 in IDLE.
REQ-034 Slave never ready, TIMEOUT_CYCLES=4, m0 addr 0x02000000 -> m0_ready asserted with rdata 0 on the 5th granted cycle; bus_err=1, bus_err_addr=0x02000000; a second timeout at 0x03000000 leaves bus_err_addr unchanged.
REQ-035 mem_ready arrives in exactly the timeout cycle -> normal completion, bus_err stays 0.
REQ-036 rst pulsed during GNT1 with the slave stalled -> no m1_ready, mem_valid=0 next cycle, and the first tie after reset goes to m0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared definitions for the two-master memory arbiter:
//                arbiter state encoding, bus widths and default timeout.
//                Imported by the arbiter RTL, the SoC top level and benches.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    localparam int unsigned c_ADDR_W                 = 32;
    localparam int unsigned c_DATA_W                 = 32;
    localparam int unsigned c_STRB_W                 = 4;
    localparam int unsigned c_DEFAULT_TIMEOUT_CYCLES = 255;
    localparam int unsigned c_DEFAULT_TIMER_W        = 8;

    // Arbiter grant state; explicit 2-bit encoding.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter_if
//  Description : Simple valid/ready memory bus used on both sides of the
//                arbiter.
//                  valid  - request          (requester -> responder)
//                  addr   - byte address     (requester -> responder)
//                  wdata  - write data       (requester -> responder)
//                  wstrb  - byte strobes, 0 = read (requester -> responder)
//                  ready  - transfer done    (responder -> requester)
//                  rdata  - read data        (responder -> requester)
//                modport master : requester side
//                modport slave  : responder side
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if;
    import mem_arb_pkg::*;

    logic                valid;
    logic                ready;
    logic [c_ADDR_W-1:0] addr;
    logic [c_DATA_W-1:0] wdata;
    logic [c_STRB_W-1:0] wstrb;
    logic [c_DATA_W-1:0] rdata;

    modport master (output valid, addr, wdata, wstrb, input  ready, rdata);
    modport slave  (input  valid, addr, wdata, wstrb, output ready, rdata);

endinterface : mem_arbiter_if
`default_nettype wire

// File: rtl/bus_timer.sv
`default_nettype none
// ============================================================================
//  Module      : bus_timer
//  Description : Transfer timeout counter. Cleared by clr, counts up while
//                en is high, and flags expired once the count reaches
//                TIMEOUT_CYCLES. Holds at the limit until cleared.
//  Ports       : clk, rst (sync, active high)
//                clr     - restart count from 0
//                en      - count this cycle
//                expired - count == TIMEOUT_CYCLES
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_timer
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = c_DEFAULT_TIMEOUT_CYCLES,
    parameter int TIMER_W        = c_DEFAULT_TIMER_W
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic clr,
    input  wire logic en,
    output logic      expired
);

    localparam logic [TIMER_W-1:0] c_LIMIT = TIMER_W'(TIMEOUT_CYCLES);

    logic [TIMER_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_count <= '0;
        end else if (en && !expired) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign expired = (r_count == c_LIMIT);

endmodule : bus_timer
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Two-master round-robin memory arbiter with a registered
//                grant, combinational datapath muxing and a transfer
//                timeout that raises a sticky bus error.
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                m0, m1        - requester buses (slave modport)
//                mem           - downstream memory bus (master modport)
//                err_clr       - clears bus_err
//                bus_err       - sticky timeout flag
//                bus_err_addr  - address of first timed-out transfer
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = c_DEFAULT_TIMEOUT_CYCLES,
    parameter int TIMER_W        = c_DEFAULT_TIMER_W
) (
    input  wire logic          clk,
    input  wire logic          rst,
    mem_arbiter_if.slave       m0,
    mem_arbiter_if.slave       m1,
    mem_arbiter_if.master      mem,
    input  wire logic          err_clr,
    output logic               bus_err,
    output logic [c_ADDR_W-1:0] bus_err_addr
);

    arb_state_t          r_state;
    arb_state_t          w_next_state;
    logic                r_last;        // 1: m1 served last, 0: m0
    logic                w_next_last;
    logic                r_bus_err;
    logic [c_ADDR_W-1:0] r_bus_err_addr;

    logic                w_granted;
    logic                w_gnt_valid;
    logic [c_ADDR_W-1:0] w_gnt_addr;
    logic                w_expired;
    logic                w_timeout;
    logic                w_resp;
    logic [c_DATA_W-1:0] w_resp_data;

    assign w_granted = (r_state != IDLE);

    bus_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TIMER_W        (TIMER_W)
    ) u_bus_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (!w_granted),
        .en      (w_gnt_valid && !mem.ready),
        .expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_next_state;
            r_last  <= w_next_last;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_last  = r_last;
        w_gnt_valid  = 1'b0;
        w_gnt_addr   = '0;
        mem.valid    = 1'b0;
        mem.addr     = '0;
        mem.wdata    = '0;
        mem.wstrb    = '0;
        m0.ready     = 1'b0;
        m0.rdata     = '0;
        m1.ready     = 1'b0;
        m1.rdata     = '0;

        case (r_state)
            IDLE: begin
                if (m0.valid && m1.valid) begin
                    w_next_state = r_last ? GNT0 : GNT1;
                end else if (m0.valid) begin
                    w_next_state = GNT0;
                end else if (m1.valid) begin
                    w_next_state = GNT1;
                end
            end
            GNT0: begin
                w_gnt_valid = m0.valid;
                w_gnt_addr  = m0.addr;
                mem.valid   = m0.valid;
                mem.addr    = m0.addr;
                mem.wdata   = m0.wdata;
                mem.wstrb   = m0.wstrb;
            end
            GNT1: begin
                w_gnt_valid = m1.valid;
                w_gnt_addr  = m1.addr;
                mem.valid   = m1.valid;
                mem.addr    = m1.addr;
                mem.wdata   = m1.wdata;
                mem.wstrb   = m1.wstrb;
            end
            default: w_next_state = IDLE;
        endcase

        // A slave response in the timeout cycle wins over the timeout.
        w_resp      = w_gnt_valid && (mem.ready || w_expired);
        w_timeout   = w_gnt_valid && !mem.ready && w_expired;
        w_resp_data = mem.ready ? mem.rdata : '0;

        if (w_granted) begin
            if (!w_gnt_valid) begin
                // Requester withdrew mid-transfer: abandon silently.
                w_next_state = IDLE;
            end else if (w_resp) begin
                w_next_state = IDLE;
                w_next_last  = (r_state == GNT1);
            end
        end

        if (r_state == GNT0) begin
            m0.ready = w_resp;
            m0.rdata = w_resp ? w_resp_data : '0;
        end
        if (r_state == GNT1) begin
            m1.ready = w_resp;
            m1.rdata = w_resp ? w_resp_data : '0;
        end

        // Registered state is still stale in the first reset cycle.
        if (rst) begin
            mem.valid = 1'b0;
            mem.addr  = '0;
            mem.wdata = '0;
            mem.wstrb = '0;
            m0.ready  = 1'b0;
            m0.rdata  = '0;
            m1.ready  = 1'b0;
            m1.rdata  = '0;
        end
    end

    // A timeout always (re)loads the address when the flag is being
    // cleared in the same cycle, so the reported address is never stale.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bus_err      <= 1'b0;
            r_bus_err_addr <= '0;
        end else if (w_timeout) begin
            r_bus_err <= 1'b1;
            if (!r_bus_err || err_clr) begin
                r_bus_err_addr <= w_gnt_addr;
            end
        end else if (err_clr) begin
            r_bus_err <= 1'b0;
        end
    end

    assign bus_err      = r_bus_err && !rst;
    assign bus_err_addr = rst ? '0 : r_bus_err_addr;

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Self-checking bench for mem_arbiter. Directed scenarios
//                followed by random traffic, all compared every cycle
//                against a transaction-level model of the arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        err_clr;
    logic        bus_err;
    logic [31:0] bus_err_addr;

    mem_arbiter_if m0_bus();
    mem_arbiter_if m1_bus();
    mem_arbiter_if mem_bus();

    mem_arbiter #(
        .TIMEOUT_CYCLES (TO),
        .TIMER_W        (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .m0           (m0_bus),
        .m1           (m1_bus),
        .mem          (mem_bus),
        .err_clr      (err_clr),
        .bus_err      (bus_err),
        .bus_err_addr (bus_err_addr)
    );

    always #5 clk = ~clk;

    int n_asserts = 0;
    int n_fail    = 0;

    // Reference model: who owns the bus (-1 none), who was served last,
    // how many granted cycles have passed without a response, error state.
    int          own      = -1;
    int          last     = 1;
    int          age      = 0;
    bit          err      = 1'b0;
    logic [31:0] err_addr = '0;

    logic        exp_r0 = 1'b0;
    logic        exp_r1 = 1'b0;
    logic [31:0] cap_rdata0 = '0;
    int          done_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: inputs already applied at posedge+1; compare at
    // posedge+5, advance the model, return at the next posedge+1.
    task automatic cyc();
        logic        e_valid, e_r0, e_r1, vx, to;
        logic [31:0] e_addr, e_wdata, e_rd0, e_rd1, ax;
        logic [3:0]  e_strb;
        #4;
        e_valid = 1'b0; e_addr = '0; e_wdata = '0; e_strb = '0;
        e_r0 = 1'b0; e_r1 = 1'b0; e_rd0 = '0; e_rd1 = '0;
        vx = 1'b0; ax = '0; to = 1'b0;
        if (!rst && own == 0) begin
            e_valid = m0_bus.valid; e_addr = m0_bus.addr;
            e_wdata = m0_bus.wdata; e_strb = m0_bus.wstrb;
            vx = m0_bus.valid; ax = m0_bus.addr;
        end else if (!rst && own == 1) begin
            e_valid = m1_bus.valid; e_addr = m1_bus.addr;
            e_wdata = m1_bus.wdata; e_strb = m1_bus.wstrb;
            vx = m1_bus.valid; ax = m1_bus.addr;
        end
        if (!rst && own >= 0 && vx) begin
            to = !mem_bus.ready && (age == TO);
            if (own == 0) begin
                e_r0  = mem_bus.ready || to;
                e_rd0 = mem_bus.ready ? mem_bus.rdata : 32'h0;
            end else begin
                e_r1  = mem_bus.ready || to;
                e_rd1 = mem_bus.ready ? mem_bus.rdata : 32'h0;
            end
        end
        chk("mem_valid", mem_bus.valid, e_valid);
        chk("mem_addr",  mem_bus.addr,  e_addr);
        chk("mem_wdata", mem_bus.wdata, e_wdata);
        chk("mem_wstrb", mem_bus.wstrb, e_strb);
        chk("m0_ready",  m0_bus.ready,  e_r0);
        chk("m0_rdata",  m0_bus.rdata,  e_rd0);
        chk("m1_ready",  m1_bus.ready,  e_r1);
        chk("m1_rdata",  m1_bus.rdata,  e_rd1);
        chk("bus_err",      bus_err,      (rst ? 1'b0 : err));
        chk("bus_err_addr", bus_err_addr, (rst ? 32'h0 : err_addr));
        if (m0_bus.ready === 1'b1) begin
            done_q.push_back(0);
            cap_rdata0 = m0_bus.rdata;
        end
        if (m1_bus.ready === 1'b1) done_q.push_back(1);
        exp_r0 = e_r0;
        exp_r1 = e_r1;

        if (rst) begin
            own = -1; last = 1; age = 0; err = 1'b0; err_addr = '0;
        end else if (own < 0) begin
            if (err_clr) err = 1'b0;
            age = 0;
            if (m0_bus.valid && m1_bus.valid) own = (last == 1) ? 0 : 1;
            else if (m0_bus.valid)            own = 0;
            else if (m1_bus.valid)            own = 1;
        end else begin
            if (to) begin
                if (!err || err_clr) err_addr = ax;
                err = 1'b1;
            end else if (err_clr) begin
                err = 1'b0;
            end
            if (!vx) begin
                own = -1;
            end else if (mem_bus.ready || to) begin
                last = own;
                own  = -1;
            end else begin
                age++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rand_m0();
        m0_bus.addr  = $urandom;
        m0_bus.wdata = $urandom;
        m0_bus.wstrb = ($urandom % 2 == 0) ? 4'h0 : 4'($urandom);
    endtask

    task automatic rand_m1();
        m1_bus.addr  = $urandom;
        m1_bus.wdata = $urandom;
        m1_bus.wstrb = ($urandom % 2 == 0) ? 4'h0 : 4'($urandom);
    endtask

    initial begin
        rst = 1'b1; err_clr = 1'b0;
        m0_bus.valid = 1'b0; m0_bus.addr = '0; m0_bus.wdata = '0; m0_bus.wstrb = '0;
        m1_bus.valid = 1'b0; m1_bus.addr = '0; m1_bus.wdata = '0; m1_bus.wstrb = '0;
        mem_bus.ready = 1'b0; mem_bus.rdata = '0;
        @(posedge clk);
        #1;
        repeat (3) cyc();
        rst = 1'b0;
        cyc();

        // Single read from m0, slave answers one cycle after grant.
        done_q.delete();
        m0_bus.valid = 1'b1; m0_bus.addr = 32'h100; m0_bus.wstrb = 4'h0;
        cyc();
        cyc();
        mem_bus.ready = 1'b1; mem_bus.rdata = 32'hDEADBEEF;
        cyc();
        m0_bus.valid = 1'b0; mem_bus.ready = 1'b0;
        cyc();
        cyc();
        chk("single_count", done_q.size(), 1);
        chk("single_who", done_q[0], 0);
        chk("single_rdata", cap_rdata0, 32'hDEADBEEF);

        // Both masters continuously requesting after reset, zero-wait slave.
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        done_q.delete();
        m0_bus.valid = 1'b1; m1_bus.valid = 1'b1; mem_bus.ready = 1'b1;
        repeat (8) cyc();
        chk("rr_count", done_q.size(), 4);
        for (int i = 0; i < 4; i++) chk("rr_order", done_q[i], i % 2);
        m0_bus.valid = 1'b0; m1_bus.valid = 1'b0; mem_bus.ready = 1'b0;
        cyc();

        // m1 write: mem_* mirror m1 only while granted.
        m1_bus.valid = 1'b1; m1_bus.addr = 32'h03000004;
        m1_bus.wdata = 32'h12345678; m1_bus.wstrb = 4'hF;
        cyc();
        cyc();
        mem_bus.ready = 1'b1;
        cyc();
        m1_bus.valid = 1'b0; mem_bus.ready = 1'b0;
        cyc();

        // Timeout at 0x02000000, then a second one that keeps the address.
        done_q.delete();
        m0_bus.valid = 1'b1; m0_bus.addr = 32'h02000000; m0_bus.wstrb = 4'h0;
        repeat (6) cyc();
        m0_bus.valid = 1'b0;
        chk("to_count", done_q.size(), 1);
        chk("to_err", bus_err, 1'b1);
        chk("to_addr", bus_err_addr, 32'h02000000);
        m1_bus.valid = 1'b1; m1_bus.addr = 32'h03000000; m1_bus.wstrb = 4'h0;
        repeat (6) cyc();
        m1_bus.valid = 1'b0;
        chk("to2_addr", bus_err_addr, 32'h02000000);
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
        chk("clr_err", bus_err, 1'b0);

        // Timeout coinciding with err_clr reloads the address.
        m0_bus.valid = 1'b1; m0_bus.addr = 32'h04000000;
        repeat (6) cyc();
        m0_bus.valid = 1'b0;
        m1_bus.valid = 1'b1; m1_bus.addr = 32'h05000000;
        repeat (5) cyc();
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0; m1_bus.valid = 1'b0;
        chk("clr_to_err", bus_err, 1'b1);
        chk("clr_to_addr", bus_err_addr, 32'h05000000);
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;

        // Slave response in exactly the timeout cycle.
        m0_bus.valid = 1'b1; m0_bus.addr = 32'h100;
        repeat (5) cyc();
        mem_bus.ready = 1'b1; mem_bus.rdata = 32'hCAFEF00D;
        cyc();
        m0_bus.valid = 1'b0; mem_bus.ready = 1'b0;
        chk("edge_rdata", cap_rdata0, 32'hCAFEF00D);
        chk("edge_err", bus_err, 1'b0);
        cyc();

        // Reset during a stalled GNT1, then the first tie goes to m0.
        m1_bus.valid = 1'b1; m1_bus.addr = 32'h00000040;
        repeat (3) cyc();
        done_q.delete();
        rst = 1'b1; mem_bus.ready = 1'b1;
        cyc();
        rst = 1'b0; m0_bus.valid = 1'b1;
        cyc();
        cyc();
        chk("rst_tie_count", done_q.size(), 1);
        chk("rst_tie_who", done_q[0], 0);
        m0_bus.valid = 1'b0; m1_bus.valid = 1'b0; mem_bus.ready = 1'b0;
        cyc();

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            if (!m0_bus.valid || exp_r0) begin
                m0_bus.valid = 1'($urandom % 2);
                rand_m0();
            end else if ($urandom % 40 == 0) begin
                m0_bus.valid = 1'b0;
            end
            if (!m1_bus.valid || exp_r1) begin
                m1_bus.valid = 1'($urandom % 2);
                rand_m1();
            end else if ($urandom % 40 == 0) begin
                m1_bus.valid = 1'b0;
            end
            mem_bus.ready = ($urandom % 3 == 0);
            mem_bus.rdata = $urandom;
            err_clr       = ($urandom % 8 == 0);
            rst           = ($urandom % 150 == 0);
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule : tb_mem_arbiter
`default_nettype wire
